// File: rtl/fetch_seq.sv
// fetch_seq: instruction-fetch sequencer owning the PC, one outstanding imem fetch at a time.
//   clk, rst                     clock and synchronous active-high reset
//   fetch_halt                   suppress new requests while high
//   redirect_valid, redirect_pc  load a new PC and kill any in-flight or held fetch
//   imem_req/addr/gnt            request side of the instruction-memory bus
//   imem_rvalid/rdata            response side of the instruction-memory bus
//   instr_valid/instr/instr_pc   fetched instruction toward decode
//   instr_ready                  decode accepts the instruction
module fetch_seq #(
    parameter int PC_WIDTH = 32,
    parameter int INC_AMOUNT = 4,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fetch_halt,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_gnt,
    input  logic                imem_rvalid,
    input  logic [31:0]         imem_rdata,
    output logic                instr_valid,
    output logic [31:0]         instr,
    output logic [PC_WIDTH-1:0] instr_pc,
    input  logic                instr_ready
);
    typedef enum logic [2:0] {BOOT, REQ, WAIT, DROP, HOLD} state_t;
    localparam logic [PC_WIDTH-1:0] INC = PC_WIDTH'(INC_AMOUNT);
    state_t state;
    logic [PC_WIDTH-1:0] pc_q;
    // Requests and the held instruction are killed combinationally by a same-cycle redirect.
    assign imem_req = (state == REQ) & ~fetch_halt & ~redirect_valid;
    assign imem_addr = pc_q;
    assign instr_valid = (state == HOLD) & ~redirect_valid;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BOOT;
            pc_q <= RESET_VECTOR;
            instr <= '0;
            instr_pc <= '0;
        end else begin
            case (state)
                BOOT: state <= REQ;
                REQ: begin
                    if (redirect_valid) pc_q <= redirect_pc;
                    else if (imem_req && imem_gnt) state <= WAIT;
                end
                WAIT: begin
                    if (redirect_valid) begin
                        pc_q <= redirect_pc;
                        state <= imem_rvalid ? REQ : DROP;
                    end else if (imem_rvalid) begin
                        instr <= imem_rdata;
                        instr_pc <= pc_q;
                        pc_q <= pc_q + INC;
                        state <= HOLD;
                    end
                end
                // The killed response is still owed by memory; swallow it before re-requesting.
                DROP: begin
                    if (redirect_valid) pc_q <= redirect_pc;
                    if (imem_rvalid) state <= REQ;
                end
                HOLD: begin
                    if (redirect_valid) begin
                        pc_q <= redirect_pc;
                        state <= REQ;
                    end else if (instr_ready) state <= REQ;
                end
                default: state <= BOOT;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_seq.sv
// tb_fetch_seq: directed self-checking bench for fetch_seq.
module tb_fetch_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, halt = 1'b0, rv = 1'b0, gnt = 1'b0, rvalid = 1'b0, ready = 1'b0;
    logic [31:0] rpc = '0, rdata = '0;
    logic req, ivalid;
    logic [31:0] addr, ins, ipc;

    logic b_rst = 1'b1, b_gnt = 1'b0, b_rvalid = 1'b0, b_ready = 1'b0;
    logic [31:0] b_rdata = '0;
    logic b_req, b_ivalid;
    logic [31:0] b_addr, b_ins, b_ipc;

    int pass = 0, total = 0;

    fetch_seq #(.PC_WIDTH(32), .INC_AMOUNT(4), .RESET_VECTOR(32'h100)) dut (
        .clk(clk), .rst(rst), .fetch_halt(halt), .redirect_valid(rv), .redirect_pc(rpc),
        .imem_req(req), .imem_addr(addr), .imem_gnt(gnt), .imem_rvalid(rvalid),
        .imem_rdata(rdata), .instr_valid(ivalid), .instr(ins), .instr_pc(ipc),
        .instr_ready(ready)
    );

    fetch_seq #(.PC_WIDTH(32), .INC_AMOUNT(4), .RESET_VECTOR(32'hFFFF_FFFC)) dut_b (
        .clk(clk), .rst(b_rst), .fetch_halt(1'b0), .redirect_valid(1'b0), .redirect_pc(32'h0),
        .imem_req(b_req), .imem_addr(b_addr), .imem_gnt(b_gnt), .imem_rvalid(b_rvalid),
        .imem_rdata(b_rdata), .instr_valid(b_ivalid), .instr(b_ins), .instr_pc(b_ipc),
        .instr_ready(b_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        #1;
        total++; if (req !== 1'b0 || ivalid !== 1'b0) $display("FAIL rst_ctl: req=%b valid=%b want 0 0", req, ivalid); else pass++;
        total++; if (ins !== 32'h0 || ipc !== 32'h0) $display("FAIL rst_data: instr=%h pc=%h want 0 0", ins, ipc); else pass++;
        rst = 1'b0;
        #1;
        total++; if (req !== 1'b0) $display("FAIL boot_req: got %b want 0", req); else pass++;
        tick();
        total++; if (req !== 1'b1 || addr !== 32'h100) $display("FAIL first_req: req=%b addr=%h want 1 100", req, addr); else pass++;
    endtask

    task automatic test_sequential();
        logic [31:0] d;
        gnt = 1'b1;
        ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            d = 32'hA000_0000 + k;
            #1;
            total++; if (req !== 1'b1 || addr !== 32'h100 + 4 * k) $display("FAIL seq_req%0d: req=%b addr=%h want 1 %h", k, req, addr, 32'h100 + 4 * k); else pass++;
            tick();
            rvalid = 1'b1;
            rdata = d;
            #1;
            total++; if (req !== 1'b0 || ivalid !== 1'b0) $display("FAIL seq_wait%0d: req=%b valid=%b want 0 0", k, req, ivalid); else pass++;
            tick();
            rvalid = 1'b0;
            rdata = 32'h0;
            #1;
            total++; if (ivalid !== 1'b1 || ins !== d || ipc !== 32'h100 + 4 * k) $display("FAIL seq_out%0d: valid=%b instr=%h pc=%h want 1 %h %h", k, ivalid, ins, ipc, d, 32'h100 + 4 * k); else pass++;
            tick();
        end
    endtask

    task automatic test_redirect_wait();
        tick();
        gnt = 1'b0;
        rv = 1'b1;
        rpc = 32'h2000;
        #1;
        total++; if (req !== 1'b0 || ivalid !== 1'b0) $display("FAIL redir_wait: req=%b valid=%b want 0 0", req, ivalid); else pass++;
        tick();
        rv = 1'b0;
        rvalid = 1'b1;
        rdata = 32'hDEAD_BEEF;
        #1;
        total++; if (req !== 1'b0 || ivalid !== 1'b0 || addr !== 32'h2000) $display("FAIL redir_drop: req=%b valid=%b addr=%h want 0 0 2000", req, ivalid, addr); else pass++;
        tick();
        rvalid = 1'b0;
        #1;
        total++; if (req !== 1'b1 || ivalid !== 1'b0 || addr !== 32'h2000) $display("FAIL redir_req: req=%b valid=%b addr=%h want 1 0 2000", req, ivalid, addr); else pass++;
    endtask

    task automatic test_hold();
        gnt = 1'b1;
        ready = 1'b0;
        tick();
        gnt = 1'b0;
        rvalid = 1'b1;
        rdata = 32'h1234_5678;
        tick();
        rvalid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            total++; if (ivalid !== 1'b1 || ins !== 32'h1234_5678 || ipc !== 32'h2000 || req !== 1'b0) $display("FAIL hold%0d: valid=%b instr=%h pc=%h req=%b want 1 12345678 2000 0", k, ivalid, ins, ipc, req); else pass++;
            tick();
        end
        ready = 1'b1;
        tick();
        #1;
        total++; if (req !== 1'b1 || addr !== 32'h2004 || ivalid !== 1'b0) $display("FAIL hold_rel: req=%b addr=%h valid=%b want 1 2004 0", req, addr, ivalid); else pass++;
    endtask

    task automatic test_redirect_hold_halt();
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        rvalid = 1'b1;
        rdata = 32'h5555_AAAA;
        tick();
        rvalid = 1'b0;
        rv = 1'b1;
        rpc = 32'h3000;
        #1;
        total++; if (ivalid !== 1'b0) $display("FAIL hold_kill: valid=%b want 0", ivalid); else pass++;
        tick();
        rv = 1'b0;
        #1;
        total++; if (req !== 1'b1 || addr !== 32'h3000) $display("FAIL kill_req: req=%b addr=%h want 1 3000", req, addr); else pass++;
        halt = 1'b1;
        gnt = 1'b1;
        #1;
        total++; if (req !== 1'b0) $display("FAIL halt_req: got %b want 0", req); else pass++;
        tick();
        #1;
        total++; if (req !== 1'b0 || addr !== 32'h3000) $display("FAIL halt_hold: req=%b addr=%h want 0 3000", req, addr); else pass++;
        gnt = 1'b0;
        halt = 1'b0;
        #1;
        total++; if (req !== 1'b1) $display("FAIL halt_rel: got %b want 1", req); else pass++;
    endtask

    task automatic test_wrap();
        b_rst = 1'b0;
        tick();
        #1;
        total++; if (b_req !== 1'b1 || b_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_req: req=%b addr=%h want 1 fffffffc", b_req, b_addr); else pass++;
        b_gnt = 1'b1;
        tick();
        b_gnt = 1'b0;
        b_rvalid = 1'b1;
        b_rdata = 32'hCAFE_F00D;
        tick();
        b_rvalid = 1'b0;
        #1;
        total++; if (b_ivalid !== 1'b1 || b_ipc !== 32'hFFFF_FFFC || b_ins !== 32'hCAFE_F00D) $display("FAIL wrap_out: valid=%b pc=%h instr=%h want 1 fffffffc cafef00d", b_ivalid, b_ipc, b_ins); else pass++;
        b_ready = 1'b1;
        tick();
        #1;
        total++; if (b_req !== 1'b1 || b_addr !== 32'h0) $display("FAIL wrap_addr: req=%b addr=%h want 1 0", b_req, b_addr); else pass++;
    endtask

    task automatic test_reset_in_wait();
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        rst = 1'b1;
        tick();
        #1;
        total++; if (req !== 1'b0 || ivalid !== 1'b0 || ins !== 32'h0 || ipc !== 32'h0) $display("FAIL rw_reset: req=%b valid=%b instr=%h pc=%h want 0 0 0 0", req, ivalid, ins, ipc); else pass++;
        rst = 1'b0;
        rvalid = 1'b1;
        rdata = 32'h0000_0BAD;
        #1;
        total++; if (req !== 1'b0 || ivalid !== 1'b0) $display("FAIL rw_boot: req=%b valid=%b want 0 0", req, ivalid); else pass++;
        tick();
        rvalid = 1'b0;
        #1;
        total++; if (req !== 1'b1 || addr !== 32'h100 || ivalid !== 1'b0) $display("FAIL rw_restart: req=%b addr=%h valid=%b want 1 100 0", req, addr, ivalid); else pass++;
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        rvalid = 1'b1;
        rdata = 32'h0000_600D;
        tick();
        rvalid = 1'b0;
        #1;
        total++; if (ivalid !== 1'b1 || ins !== 32'h0000_600D || ipc !== 32'h100) $display("FAIL rw_fetch: valid=%b instr=%h pc=%h want 1 0000600d 100", ivalid, ins, ipc); else pass++;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_redirect_wait();
        test_hold();
        test_redirect_hold_halt();
        test_wrap();
        test_reset_in_wait();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", pass, total);
        $fatal(1);
    end
endmodule
